// File: rtl/dispatch_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_pkg
// Shared definitions for the in-order dispatch scheduler: instruction class
// encodings (also the bit index into the one-hot issue vector), scheduler
// FSM state encodings, tag width and the enqueue-time classifier.
// -----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int CLS_W       = 2;
    localparam int TAG_W       = 3;

    // Class value doubles as the iss_valid / iss_ready bit position.
    typedef enum logic [CLS_W-1:0] {
        CLS_INT = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2,
        CLS_JMP = 2'd3
    } iclass_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    // Control-flow flags dominate memory flags so that a jump or branch
    // always serialises the pipeline, whatever else the decoder reported.
    function automatic iclass_e classify(
        input logic memread,
        input logic memwrite,
        input logic beq,
        input logic bne,
        input logic jump,
        input logic jumpr
    );
        iclass_e cls;
        if (jump || jumpr) begin
            cls = CLS_JMP;
        end else if (beq || bne) begin
            cls = CLS_BR;
        end else if (memread || memwrite) begin
            cls = CLS_MEM;
        end else begin
            cls = CLS_INT;
        end
        return cls;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// -----------------------------------------------------------------------------
// dispatch_fifo
// Instruction queue storage: DEPTH entries of W bits, head always visible.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   push, wr_data- enqueue request (ignored when full)
//   pop          - dequeue request (ignored when empty)
//   flush        - clear pointers and count; takes precedence over push/pop
//   rd_data      - current head entry (meaningful only when !empty)
//   full, empty  - occupancy status
// -----------------------------------------------------------------------------
module dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap for free; the count
    // carries one extra bit to tell full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data array needs no reset: an entry is only observed once the count
    // covers it.
    always_ff @(posedge clk) begin
        if (rst_n && do_push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// dispatch_scheduler
// In-order dispatch of decoded instructions to four reservation-station
// classes (INT, MEM, BR, JMP). Instructions are classified on entry, queued,
// and issued from the head only. After a branch/jump issues, dispatch stalls
// until it resolves; a mispredict triggers a one-cycle queue flush.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid / in_ready     - decoded instruction handshake
//   in_memread..in_jumpr    - decode flags used for classification
//   in_payload              - opaque instruction fields
//   iss_valid / iss_ready   - one-hot per-class issue handshake
//   iss_payload, iss_tag    - head payload and dispatch sequence tag
//   br_resolve, br_mispredict - outcome of the outstanding branch/jump
//   busy                    - queue non-empty or not in RUN
// -----------------------------------------------------------------------------
module dispatch_scheduler
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_memread,
    input  logic                   in_memwrite,
    input  logic                   in_beq,
    input  logic                   in_bne,
    input  logic                   in_jump,
    input  logic                   in_jumpr,
    input  logic [PW-1:0]          in_payload,
    output logic [NUM_CLASSES-1:0] iss_valid,
    input  logic [NUM_CLASSES-1:0] iss_ready,
    output logic [PW-1:0]          iss_payload,
    output logic [TAG_W-1:0]       iss_tag,
    input  logic                   br_resolve,
    input  logic                   br_mispredict,
    output logic                   busy
);

    localparam int EW = PW + CLS_W;

    state_e           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    iclass_e          in_cls;
    iclass_e          head_cls;
    logic [EW-1:0]    wr_word;
    logic [EW-1:0]    head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             dispatch;
    logic             flush;

    assign in_cls    = classify(in_memread, in_memwrite, in_beq, in_bne, in_jump, in_jumpr);
    assign wr_word   = {in_cls, in_payload};
    assign head_cls  = iclass_e'(head_word[EW-1:PW]);

    // No push-through when full: in_ready depends only on registered state.
    assign in_ready  = !fifo_full && (state_q != ST_FLUSH);
    assign push      = in_valid && in_ready;
    assign flush     = (state_q == ST_FLUSH);
    assign dispatch  = |(iss_valid & iss_ready);

    assign iss_payload = head_word[PW-1:0];
    assign iss_tag     = tag_q;
    assign busy        = !fifo_empty || (state_q != ST_RUN);

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_word),
        .pop     (dispatch),
        .flush   (flush),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Only the head's class line is raised, and only while running.
    always_comb begin
        iss_valid = '0;
        if ((state_q == ST_RUN) && !fifo_empty) begin
            iss_valid[head_cls] = 1'b1;
        end
    end

    // Branch/jump dispatch parks the scheduler until the outcome is known;
    // resolve is only meaningful while waiting.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        if (dispatch) begin
            tag_d = tag_q + 1'b1;
        end
        case (state_q)
            ST_RUN: begin
                if (dispatch && ((head_cls == CLS_BR) || (head_cls == CLS_JMP))) begin
                    state_d = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (br_resolve) begin
                    state_d = br_mispredict ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

endmodule
